vdec_hs_crc: RTL and testbench
==============================

Name: vdec_hs_crc

Overview:
- CRC check engine started by the HS decoder FSM after Viterbi traceback.
- Serially reads decoded hard bits from the traceback bit buffer and computes CRC-16 over the info bits.
- XORs the result with the UE identity mask for the current channel and compares it against the received 16 parity bits.
- Reports crc_match with a one-cycle crc_done pulse; serves HS-SCCH part2 (one check) and AGCH (primary/secondary E-RNTI, up to two checks).

Parameters:
- ADDR_W, 7, bit-buffer address width.
- LEN_W, 6, width of info_len.
- POLY, 16'h1021, CRC-16 generator (x^16+x^12+x^5+1).

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- crc_start  input  1  one-cycle start pulse
- crc_done  output  1  one-cycle completion pulse
- crc_match  output  1  result; valid from the crc_done cycle, held until the next accepted start
- hs_mode  input  2  00 part1, 01 HS-SCCH part2, 10/11 AGCH
- agch_crc_sel  input  1  0 primary E-RNTI mask, 1 secondary; sampled at start
- ue_id  input  16  H-RNTI mask
- ernti_pri  input  16  primary E-RNTI mask
- ernti_sec  input  16  secondary E-RNTI mask
- info_len  input  LEN_W  number of info bits K, sampled at start
- mem_rd_en  output  1  bit-buffer read strobe
- mem_rd_addr  output  ADDR_W  bit-buffer address
- mem_rd_data  input  1  decoded bit; valid 1 cycle after mem_rd_en
- busy  output  1  high from the cycle after an accepted start through the crc_done cycle

Behaviour:
- Clock is clk; reset is rst, asynchronous and active-high.
- Reset values: all outputs 0. Internal state: FSM IDLE, crc_reg 0, rx_reg 0, counters 0.
- Buffer layout: info bits at addresses 0..K-1; received parity at K..K+15, MSB first.
- FSM has four states: IDLE, READ, CMP, DONE.
- IDLE:
  - On crc_start, latch info_len, hs_mode, agch_crc_sel and the selected mask; go to READ.
  - Mask selection: hs_mode 01 -> ue_id; 1x -> agch_crc_sel ? ernti_sec : ernti_pri; 00 -> 16'h0000.
- READ:
  - Issue mem_rd_en=1 with mem_rd_addr = 0,1,...,K+15, one per cycle, N=K+16 reads total.
  - A registered valid flag tracks the 1-cycle read latency.
  - On each valid data bit at index i < K: fb = d ^ crc_reg[15]; crc_reg = {crc_reg[14:0],1'b0} ^ (fb ? POLY : 0).
  - On each valid bit at index i >= K: rx_reg = {rx_reg[14:0], d}.
  - After the last read is issued, wait for its data, then go to CMP.
- CMP: match_next = ((crc_reg ^ mask) == rx_reg); go to DONE.
- DONE: crc_done=1 and crc_match registered for exactly 1 cycle; return to IDLE.
- Latency: crc_done rises N+3 cycles after the crc_start cycle (start at cycle 0, reads at cycles 1..N, last data at N+1, CMP at N+2, done at N+3).
- Back-to-back: crc_start is accepted in IDLE only, including the cycle right after DONE. This supports the AGCH CRC1 -> CRC2 sequence; crc_reg and rx_reg clear on accept.
- crc_start while busy is ignored, with no effect on the current check.
- K=0: no CRC updates (crc_reg stays 0); the 16 parity reads still occur.
- K > 2^ADDR_W-16: out of range, behaviour unspecified. The bench must not drive it.
- Mask inputs may change during a check without effect (latched at start).
- Reset mid-operation aborts immediately: no crc_done, all outputs 0.

Decomposition:
- Shared package vdec_hs_pkg holds:
  - hs_mode encodings HS_PART1=2'b00, HS_PART2=2'b01, HS_AGCH=2'b10.
  - CRC16_POLY.
  - CRC_LEN=16.
- One sub-module, vdec_crc16_ser: a single-bit serial CRC-16 LFSR with clear/enable/data inputs and a 16-bit state output.
- The top holds the FSM, address counter, rx shift register and compare logic.

Test Plan:
- Zero info, part2: K=21, all info bits 0, parity bits = ue_id 16'hA5C3 -> crc_done at cycle 40, crc_match=1; mem_rd_addr sweeps 0..36.
- Single-bit info: K=1, bit=1, hs_mode=01, ue_id=0, parity=16'h1021 -> crc_match=1; parity=16'h1020 -> crc_match=0.
- AGCH secondary: K=6 zero info, parity=16'h1234, ernti_pri=16'hFFFF, ernti_sec=16'h1234.
  - First check with agch_crc_sel=0 -> match=0.
  - crc_start in the cycle after DONE with sel=1 -> match=1, done 25 cycles later.
- Ignored start: pulse crc_start again at cycle 5 of a K=21 check -> exactly one crc_done at cycle 40, address sequence undisturbed.
- Reset mid-op: assert rst at cycle 10 of a check -> crc_done, busy and mem_rd_en go 0 asynchronously, no done pulse afterwards; a new start after reset completes normally.
- K=0, hs_mode=00, parity=16'h0000 -> match=1 at cycle 19; parity=16'h0001 -> match=0.

Source files
------------

// File: rtl/vdec_hs_pkg.sv
// Shared definitions for the HS decoder CRC check path.
// Mode encodings, CRC-16 constants and check FSM states.
package vdec_hs_pkg;

  localparam logic [1:0] HS_PART1 = 2'b00;
  localparam logic [1:0] HS_PART2 = 2'b01;
  localparam logic [1:0] HS_AGCH  = 2'b10;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam int          CRC_LEN    = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_READ = 2'b01,
    ST_CMP  = 2'b10,
    ST_DONE = 2'b11
  } crc_state_t;

endpackage

// File: rtl/vdec_crc16_ser.sv
// Single-bit serial CRC-16 LFSR.
// Clear has priority over a data step.
module vdec_crc16_ser
  import vdec_hs_pkg::*;
#(
  parameter logic [15:0] POLY = CRC16_POLY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;
  logic        fb;

  always_comb begin
    crc_d = crc_q;
    fb    = din ^ crc_q[15];
    if (clr) begin
      crc_d = '0;
    end else if (en) begin
      crc_d = {crc_q[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_q <= '0;
    else     crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/vdec_hs_crc.sv
// CRC check engine: streams decoded bits from the bit buffer,
// runs CRC-16 over the info bits and compares against masked parity.
module vdec_hs_crc
  import vdec_hs_pkg::*;
#(
  parameter int          ADDR_W = 7,
  parameter int          LEN_W  = 6,
  parameter logic [15:0] POLY   = 16'h1021
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              crc_start,
  output logic              crc_done,
  output logic              crc_match,
  input  logic [1:0]        hs_mode,
  input  logic              agch_crc_sel,
  input  logic [15:0]       ue_id,
  input  logic [15:0]       ernti_pri,
  input  logic [15:0]       ernti_sec,
  input  logic [LEN_W-1:0]  info_len,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_data,
  output logic              busy
);

  crc_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [15:0]       mask_q, mask_d;
  logic [15:0]       rx_q, rx_d;
  logic              vld_q, vld_d;
  logic              match_q, match_d;
  logic              crc_clr, crc_en, rd_en;
  logic [15:0]       crc;
  logic [15:0]       mask_sel;

  vdec_crc16_ser #(.POLY(POLY)) u_crc (
    .clk (clk),
    .rst (rst),
    .clr (crc_clr),
    .en  (crc_en),
    .din (mem_rd_data),
    .crc (crc)
  );

  always_comb begin
    mask_sel = 16'h0000;
    if (hs_mode == HS_PART2)  mask_sel = ue_id;
    else if (hs_mode[1])      mask_sel = agch_crc_sel ? ernti_sec : ernti_pri;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    n_d     = n_q;
    k_d     = k_q;
    mask_d  = mask_q;
    rx_d    = rx_q;
    vld_d   = 1'b0;
    match_d = match_q;
    crc_clr = 1'b0;
    crc_en  = 1'b0;
    rd_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (crc_start) begin
          k_d     = ADDR_W'(info_len);
          n_d     = ADDR_W'(info_len) + ADDR_W'(CRC_LEN);
          mask_d  = mask_sel;
          addr_d  = '0;
          rx_d    = '0;
          match_d = 1'b0;
          crc_clr = 1'b1;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        rd_en = (addr_q != n_q);
        vld_d = rd_en;
        idx_d = addr_q;
        if (rd_en) addr_d = addr_q + 1'b1;
        // Data arriving now belongs to the read issued last cycle.
        if (vld_q) begin
          if (idx_q < k_q) crc_en = 1'b1;
          else             rx_d = {rx_q[14:0], mem_rd_data};
        end
        if (!rd_en && vld_q) state_d = ST_CMP;
      end
      ST_CMP: begin
        match_d = ((crc ^ mask_q) == rx_q);
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      n_q     <= '0;
      k_q     <= '0;
      mask_q  <= '0;
      rx_q    <= '0;
      vld_q   <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      k_q     <= k_d;
      mask_q  <= mask_d;
      rx_q    <= rx_d;
      vld_q   <= vld_d;
      match_q <= match_d;
    end
  end

  assign mem_rd_en   = rd_en;
  assign mem_rd_addr = addr_q;
  assign busy        = (state_q != ST_IDLE);
  assign crc_done    = (state_q == ST_DONE);
  assign crc_match   = match_q;

endmodule

// File: tb/tb_vdec_hs_crc.sv
// Directed bench for vdec_hs_crc with a behavioural bit buffer.
// Vector table plus back-to-back, ignored-start and reset sequences.
module tb_vdec_hs_crc;

  logic        clk = 1'b0;
  logic        rst;
  logic        crc_start;
  logic        crc_done;
  logic        crc_match;
  logic [1:0]  hs_mode;
  logic        agch_crc_sel;
  logic [15:0] ue_id;
  logic [15:0] ernti_pri;
  logic [15:0] ernti_sec;
  logic [5:0]  info_len;
  logic        mem_rd_en;
  logic [6:0]  mem_rd_addr;
  logic        mem_rd_data;
  logic        busy;

  logic mem [0:127];

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          k;
    logic [63:0] info;
    logic [1:0]  mode;
    logic        sel;
    logic [15:0] ue;
    logic [15:0] pri;
    logic [15:0] sec;
    logic [15:0] par;
    logic        exp;
  } vec_t;

  vec_t tv [12];

  vdec_hs_crc dut (
    .clk          (clk),
    .rst          (rst),
    .crc_start    (crc_start),
    .crc_done     (crc_done),
    .crc_match    (crc_match),
    .hs_mode      (hs_mode),
    .agch_crc_sel (agch_crc_sel),
    .ue_id        (ue_id),
    .ernti_pri    (ernti_pri),
    .ernti_sec    (ernti_sec),
    .info_len     (info_len),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rd_data <= mem_rd_en ? mem[mem_rd_addr] : 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input vec_t v);
    for (int i = 0; i < v.k; i++) mem[i] = v.info[i];
    for (int j = 0; j < 16; j++) mem[v.k + j] = v.par[15 - j];
    hs_mode      = v.mode;
    agch_crc_sel = v.sel;
    ue_id        = v.ue;
    ernti_pri    = v.pri;
    ernti_sec    = v.sec;
    info_len     = 6'(v.k);
  endtask

  task automatic run_check(input vec_t v, input int ign_at,
                           input bit post, input string tag);
    int cyc;
    int rd;
    int bad;
    int busy_bad;
    int extra;
    bit seen;
    @(negedge clk);
    load(v);
    crc_start = 1'b1;
    cyc = 0; rd = 0; bad = 0; busy_bad = 0; seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      crc_start = (cyc == ign_at);
      if (cyc == 3) begin
        ue_id        = ~ue_id;
        ernti_pri    = ~ernti_pri;
        ernti_sec    = ~ernti_sec;
        agch_crc_sel = ~agch_crc_sel;
        hs_mode      = ~hs_mode;
        info_len     = ~info_len;
      end
      if (!busy) busy_bad++;
      if (mem_rd_en) begin
        if (int'(mem_rd_addr) != rd) bad++;
        rd++;
      end
      if (crc_done) seen = 1'b1;
    end
    crc_start = 1'b0;
    chk({tag, "_latency"}, seen ? cyc : 0, v.k + 19);
    chk({tag, "_match"}, crc_match, v.exp);
    chk({tag, "_nreads"}, rd, v.k + 16);
    chk({tag, "_addr_seq"}, bad, 0);
    chk({tag, "_busy"}, busy_bad, 0);
    if (post) begin
      extra = 0;
      repeat (4) begin
        @(negedge clk);
        if (crc_done || busy || mem_rd_en) extra++;
      end
      chk({tag, "_idle_after"}, extra, 0);
      chk({tag, "_match_held"}, crc_match, v.exp);
    end
  endtask

  initial begin
    int dones;
    tv[0]  = '{21, 64'h0, 2'b01, 1'b0, 16'hA5C3, 16'h0000, 16'h0000, 16'hA5C3, 1'b1};
    tv[1]  = '{1,  64'h1, 2'b01, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h1021, 1'b1};
    tv[2]  = '{1,  64'h1, 2'b01, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h1020, 1'b0};
    tv[3]  = '{0,  64'h0, 2'b00, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1};
    tv[4]  = '{0,  64'h0, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 1'b0};
    tv[5]  = '{6,  64'h0, 2'b10, 1'b0, 16'h0000, 16'hFFFF, 16'h1234, 16'h1234, 1'b0};
    tv[6]  = '{6,  64'h0, 2'b10, 1'b1, 16'h0000, 16'hFFFF, 16'h1234, 16'h1234, 1'b1};
    tv[7]  = '{2,  64'h1, 2'b01, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h2042, 1'b1};
    tv[8]  = '{3,  64'h7, 2'b11, 1'b0, 16'h0000, 16'h00FF, 16'h0000, 16'h7018, 1'b1};
    tv[9]  = '{5,  64'h1, 2'b01, 1'b0, 16'h0001, 16'h0000, 16'h0000, 16'h1230, 1'b1};
    tv[10] = '{1,  64'h1, 2'b00, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h1021, 1'b1};
    tv[11] = '{5,  64'h1, 2'b01, 1'b0, 16'h0001, 16'h0000, 16'h0000, 16'h1231, 1'b0};

    for (int i = 0; i < 128; i++) mem[i] = 1'b0;
    rst = 1'b1;
    crc_start = 1'b0;
    hs_mode = 2'b00;
    agch_crc_sel = 1'b0;
    ue_id = 16'h0;
    ernti_pri = 16'h0;
    ernti_sec = 16'h0;
    info_len = 6'd0;
    repeat (3) @(negedge clk);
    chk("rst_done", crc_done, 1'b0);
    chk("rst_match", crc_match, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_en", mem_rd_en, 1'b0);
    chk("rst_rd_addr", mem_rd_addr, 7'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      run_check(tv[i], 0, 1'b1, $sformatf("vec%0d", i));

    run_check(tv[5], 0, 1'b0, "b2b_pri");
    run_check(tv[6], 0, 1'b1, "b2b_sec");

    run_check(tv[0], 5, 1'b1, "ign_start");

    @(negedge clk);
    load(tv[0]);
    crc_start = 1'b1;
    @(negedge clk);
    crc_start = 1'b0;
    repeat (9) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_rd_en", mem_rd_en, 1'b0);
    chk("mid_rst_done", crc_done, 1'b0);
    chk("mid_rst_match", crc_match, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (50) begin
      @(negedge clk);
      if (crc_done) dones++;
    end
    chk("mid_rst_no_done", dones, 0);
    run_check(tv[0], 0, 1'b1, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
